pong_game_engine: RTL and testbench

PONG_GAME_ENGINE -- requirements
Module: pong_game_engine

---
 rtl/pong_pkg.sv | 27 ++
 rtl/pong_paddle.sv | 46 ++++
 rtl/pong_game_engine.sv | 182 ++++++++++++++++++
 tb/tb_pong_game_engine.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared FSM encoding, direction bits and default geometry for the pong engine.
package pong_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_PLAY  = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   localparam logic DIR_RIGHT = 1'b1;
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_DOWN  = 1'b1;
   localparam logic DIR_UP    = 1'b0;

   localparam int DEF_H_ACTIVE     = 640;
   localparam int DEF_V_ACTIVE     = 480;
   localparam int DEF_PADDLE_H     = 64;
   localparam int DEF_PADDLE_W     = 8;
   localparam int DEF_BALL_SZ      = 8;
   localparam int DEF_PADDLE_STEP  = 4;
   localparam int DEF_BALL_STEP    = 2;
   localparam int DEF_WIN_SCORE    = 7;
   localparam int DEF_SERVE_FRAMES = 60;
   localparam int DEF_SCORE_W      = 4;

endpackage

// File: rtl/pong_paddle.sv
// One paddle: per-frame up/down step with clamping to the visible column.
module pong_paddle
   import pong_pkg::*;
#(
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int PADDLE_H    = DEF_PADDLE_H,
   parameter int PADDLE_STEP = DEF_PADDLE_STEP
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_en,
   input  logic       i_up,
   input  logic       i_down,
   output logic [9:0] o_y
);

   localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - PADDLE_H);
   localparam logic [10:0] STEP  = 11'(PADDLE_STEP);
   localparam logic [9:0]  Y_RST = 10'((V_ACTIVE - PADDLE_H) / 2);

   logic [9:0]  r_y;
   logic [10:0] w_y;
   logic [10:0] w_dn;
   logic [9:0]  w_next;

   // 11-bit math so neither direction can wrap before the clamp
   always_comb begin
      w_y    = {1'b0, r_y};
      w_dn   = w_y + STEP;
      w_next = r_y;
      if (i_up && !i_down)
         w_next = (w_y < STEP) ? 10'd0 : 10'(w_y - STEP);
      else if (i_down && !i_up)
         w_next = (w_dn > Y_MAX) ? Y_MAX[9:0] : w_dn[9:0];
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset)
         r_y <= Y_RST;
      else if (i_en)
         r_y <= w_next;
   end

   assign o_y = r_y;

endmodule

// File: rtl/pong_game_engine.sv
// Pong game state: serve/play/score FSM, ball physics and two paddles.
// Define PONG_AI_PLAYER_EN to make the right paddle track the ball.
module pong_game_engine
   import pong_pkg::*;
#(
   parameter int H_ACTIVE     = DEF_H_ACTIVE,
   parameter int V_ACTIVE     = DEF_V_ACTIVE,
   parameter int PADDLE_H     = DEF_PADDLE_H,
   parameter int PADDLE_W     = DEF_PADDLE_W,
   parameter int BALL_SZ      = DEF_BALL_SZ,
   parameter int PADDLE_STEP  = DEF_PADDLE_STEP,
   parameter int BALL_STEP    = DEF_BALL_STEP,
   parameter int WIN_SCORE    = DEF_WIN_SCORE,
   parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
   parameter int SCORE_W      = DEF_SCORE_W
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_frame_tick,
   input  logic [1:0]         i_up_but,
   input  logic [1:0]         i_down_but,
   input  logic               i_start,
   output logic [9:0]         o_paddle_l_y,
   output logic [9:0]         o_paddle_r_y,
   output logic [9:0]         o_ball_x,
   output logic [9:0]         o_ball_y,
   output logic [SCORE_W-1:0] o_score_l,
   output logic [SCORE_W-1:0] o_score_r,
   output logic [1:0]         o_state,
   output logic               o_winner
);

   localparam int CNT_W = $clog2(SERVE_FRAMES + 2);
   localparam logic [9:0] BX_C = 10'((H_ACTIVE - BALL_SZ) / 2);
   localparam logic [9:0] BY_C = 10'((V_ACTIVE - BALL_SZ) / 2);
   localparam logic signed [11:0] S_BSTEP  = 12'(BALL_STEP);
   localparam logic signed [11:0] S_BY_MAX = 12'(V_ACTIVE - BALL_SZ);
   localparam logic signed [11:0] S_BX_MAX = 12'(H_ACTIVE - BALL_SZ);
   localparam logic signed [11:0] S_FACE_L = 12'(PADDLE_W);
   localparam logic signed [11:0] S_FACE_R = 12'(H_ACTIVE - PADDLE_W - BALL_SZ);
   localparam logic signed [11:0] S_PH_M1  = 12'(PADDLE_H - 1);
   localparam logic signed [11:0] S_B_M1   = 12'(BALL_SZ - 1);

   state_t             r_state;
   logic [9:0]         r_bx, r_by;
   logic               r_dx, r_dy;
   logic [CNT_W-1:0]   r_cnt;
   logic [SCORE_W-1:0] r_score_l, r_score_r;
   logic               r_winner;

   logic [9:0]         w_pl, w_pr;
   logic               w_pad_en, w_r_up, w_r_dn;
   logic signed [11:0] w_bx_s, w_by_s, w_pl_s, w_pr_s, w_nx, w_ny_raw, w_ny;
   logic               w_dy_nx, w_ov_l, w_ov_r;
   logic               w_hit_l, w_hit_r, w_miss_l, w_miss_r;
   logic [SCORE_W-1:0] w_sl_inc, w_sr_inc;

   assign w_pad_en = i_frame_tick && (r_state == ST_SERVE || r_state == ST_PLAY);

`ifdef PONG_AI_PLAYER_EN
   localparam logic signed [11:0] S_AI_OFS = 12'((PADDLE_H - BALL_SZ) / 2);
   localparam logic signed [11:0] S_PSTEP  = 12'(PADDLE_STEP);
   logic signed [11:0] w_tgt;
   assign w_tgt  = w_by_s - S_AI_OFS;
   assign w_r_up = w_tgt < (w_pr_s - S_PSTEP);
   assign w_r_dn = w_tgt > (w_pr_s + S_PSTEP);
`else
   assign w_r_up = i_up_but[1];
   assign w_r_dn = i_down_but[1];
`endif

   pong_paddle #(.V_ACTIVE(V_ACTIVE), .PADDLE_H(PADDLE_H), .PADDLE_STEP(PADDLE_STEP)) u_pad_l (
      .i_clock(i_clock), .i_reset(i_reset), .i_en(w_pad_en),
      .i_up(i_up_but[0]), .i_down(i_down_but[0]), .o_y(w_pl)
   );

   pong_paddle #(.V_ACTIVE(V_ACTIVE), .PADDLE_H(PADDLE_H), .PADDLE_STEP(PADDLE_STEP)) u_pad_r (
      .i_clock(i_clock), .i_reset(i_reset), .i_en(w_pad_en),
      .i_up(w_r_up), .i_down(w_r_dn), .o_y(w_pr)
   );

   // Hit tests use the paddle rows from before this frame's paddle move
   always_comb begin
      w_bx_s   = $signed({2'b00, r_bx});
      w_by_s   = $signed({2'b00, r_by});
      w_pl_s   = $signed({2'b00, w_pl});
      w_pr_s   = $signed({2'b00, w_pr});
      w_nx     = (r_dx == DIR_RIGHT) ? w_bx_s + S_BSTEP : w_bx_s - S_BSTEP;
      w_ny_raw = (r_dy == DIR_DOWN)  ? w_by_s + S_BSTEP : w_by_s - S_BSTEP;
      w_ny     = w_ny_raw;
      w_dy_nx  = r_dy;
      if (w_ny_raw <= 12'sd0) begin
         w_ny    = 12'sd0;
         w_dy_nx = DIR_DOWN;
      end else if (w_ny_raw >= S_BY_MAX) begin
         w_ny    = S_BY_MAX;
         w_dy_nx = DIR_UP;
      end
      w_ov_l   = (w_ny <= w_pl_s + S_PH_M1) && (w_pl_s <= w_ny + S_B_M1);
      w_ov_r   = (w_ny <= w_pr_s + S_PH_M1) && (w_pr_s <= w_ny + S_B_M1);
      w_hit_l  = (r_dx == DIR_LEFT)  && (w_bx_s >= S_FACE_L) && (w_nx <= S_FACE_L) && w_ov_l;
      w_hit_r  = (r_dx == DIR_RIGHT) && (w_bx_s <= S_FACE_R) && (w_nx >= S_FACE_R) && w_ov_r;
      w_miss_l = (r_dx == DIR_LEFT)  && !w_hit_l && (w_nx <= 12'sd0);
      w_miss_r = (r_dx == DIR_RIGHT) && !w_hit_r && (w_nx >= S_BX_MAX);
      w_sl_inc = (&r_score_l) ? r_score_l : r_score_l + 1'b1;
      w_sr_inc = (&r_score_r) ? r_score_r : r_score_r + 1'b1;
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state   <= ST_IDLE;
         r_bx      <= BX_C;
         r_by      <= BY_C;
         r_dx      <= DIR_RIGHT;
         r_dy      <= DIR_DOWN;
         r_cnt     <= '0;
         r_score_l <= '0;
         r_score_r <= '0;
         r_winner  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (i_start) begin
               r_score_l <= '0;
               r_score_r <= '0;
               r_cnt     <= CNT_W'(SERVE_FRAMES);
               r_dx      <= DIR_RIGHT;
               r_dy      <= DIR_DOWN;
               r_state   <= ST_SERVE;
            end
            ST_OVER: if (i_start) begin
               r_score_l <= '0;
               r_score_r <= '0;
               r_cnt     <= CNT_W'(SERVE_FRAMES);
               r_state   <= ST_SERVE;
            end
            ST_SERVE: if (i_frame_tick) begin
               r_bx <= BX_C;
               r_by <= BY_C;
               if (r_cnt == '0) r_state <= ST_PLAY;
               else             r_cnt   <= r_cnt - 1'b1;
            end
            ST_PLAY: if (i_frame_tick) begin
               r_bx <= w_nx[9:0];
               r_by <= w_ny[9:0];
               r_dy <= w_dy_nx;
               if (w_hit_l) begin
                  r_bx <= S_FACE_L[9:0];
                  r_dx <= DIR_RIGHT;
               end else if (w_hit_r) begin
                  r_bx <= S_FACE_R[9:0];
                  r_dx <= DIR_LEFT;
               end else if (w_miss_l || w_miss_r) begin
                  // Point: re-centre and serve toward the player who lost it
                  r_bx <= BX_C;
                  r_by <= BY_C;
                  r_dx <= w_miss_l ? DIR_LEFT : DIR_RIGHT;
                  if (w_miss_l) r_score_r <= w_sr_inc;
                  else          r_score_l <= w_sl_inc;
                  if ((w_miss_l ? w_sr_inc : w_sl_inc) == SCORE_W'(WIN_SCORE)) begin
                     r_state  <= ST_OVER;
                     r_winner <= w_miss_l;
                  end else begin
                     r_state <= ST_SERVE;
                     r_cnt   <= CNT_W'(SERVE_FRAMES);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_paddle_l_y = w_pl;
   assign o_paddle_r_y = w_pr;
   assign o_ball_x     = r_bx;
   assign o_ball_y     = r_by;
   assign o_score_l    = r_score_l;
   assign o_score_r    = r_score_r;
   assign o_state      = r_state;
   assign o_winner     = r_winner;

endmodule

// File: tb/tb_pong_game_engine.sv
// Bench for pong_game_engine: integer game model compared every cycle, plus pinned literal checks.
module tb_pong_game_engine;

   localparam int H = 640, V = 480, PH = 64, PW = 8, B = 8, PS = 4, BS = 2;
   localparam int WIN = 7, SF = 60, SMAX = 15;

   logic       i_clock = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_frame_tick = 1'b0;
   logic [1:0] i_up_but = 2'b00, i_down_but = 2'b00;
   logic       i_start = 1'b0;
   logic [9:0] o_paddle_l_y, o_paddle_r_y, o_ball_x, o_ball_y;
   logic [3:0] o_score_l, o_score_r;
   logic [1:0] o_state;
   logic       o_winner;

   int n_tests = 0, n_fail = 0;
   bit chk_on = 1'b0;

   int m_st, m_pl, m_pr, m_bx, m_by, m_dx, m_dy, m_cnt, m_sl, m_sr, m_win;

   pong_game_engine dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_frame_tick(i_frame_tick),
      .i_up_but(i_up_but), .i_down_but(i_down_but), .i_start(i_start),
      .o_paddle_l_y(o_paddle_l_y), .o_paddle_r_y(o_paddle_r_y),
      .o_ball_x(o_ball_x), .o_ball_y(o_ball_y),
      .o_score_l(o_score_l), .o_score_r(o_score_r),
      .o_state(o_state), .o_winner(o_winner)
   );

   always #5 i_clock = ~i_clock;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   function automatic bit overlap(input int a, input int alen, input int b, input int blen);
      return (a <= b + blen - 1) && (b <= a + alen - 1);
   endfunction

   task automatic m_reset();
      m_st = 0; m_pl = (V - PH) / 2; m_pr = (V - PH) / 2;
      m_bx = (H - B) / 2; m_by = (V - B) / 2; m_dx = 1; m_dy = 1;
      m_cnt = 0; m_sl = 0; m_sr = 0; m_win = 0;
   endtask

   function automatic int pad_next(input int y, input bit up, input bit dn);
      if (up == dn) return y;
      return clampi(y + (dn ? PS : -PS), 0, V - PH);
   endfunction

   // right_scored: 1 when the left player missed
   task automatic m_point(input bit right_scored);
      int s;
      if (right_scored) begin m_sr = (m_sr < SMAX) ? m_sr + 1 : SMAX; s = m_sr; end
      else              begin m_sl = (m_sl < SMAX) ? m_sl + 1 : SMAX; s = m_sl; end
      m_bx = (H - B) / 2; m_by = (V - B) / 2;
      m_dx = right_scored ? 0 : 1;
      if (s == WIN) begin m_st = 3; m_win = right_scored; end
      else begin m_st = 1; m_cnt = SF; end
   endtask

   task automatic m_step(input bit rst, input bit tick, input bit start,
                         input logic [1:0] up, input logic [1:0] dn);
      int pl0, pr0, nx, ny;
      bit rup, rdn;
      if (!rst) begin m_reset(); return; end
      pl0 = m_pl; pr0 = m_pr;
      rup = up[1]; rdn = dn[1];
`ifdef PONG_AI_PLAYER_EN
      rup = (m_by - (PH - B) / 2) < m_pr - PS;
      rdn = (m_by - (PH - B) / 2) > m_pr + PS;
`endif
      if (m_st == 0 || m_st == 3) begin
         if (start) begin
            if (m_st == 0) begin m_dx = 1; m_dy = 1; end
            m_sl = 0; m_sr = 0; m_cnt = SF; m_st = 1;
         end
         return;
      end
      if (!tick) return;
      m_pl = pad_next(pl0, up[0], dn[0]);
      m_pr = pad_next(pr0, rup, rdn);
      if (m_st == 1) begin
         m_bx = (H - B) / 2; m_by = (V - B) / 2;
         if (m_cnt == 0) m_st = 2; else m_cnt--;
         return;
      end
      nx = m_bx + (m_dx ? BS : -BS);
      ny = m_by + (m_dy ? BS : -BS);
      if (ny <= 0) begin ny = 0; m_dy = 1; end
      else if (ny >= V - B) begin ny = V - B; m_dy = 0; end
      m_by = ny;
      if (m_dx == 0) begin
         if (m_bx >= PW && nx <= PW && overlap(ny, B, pl0, PH)) begin m_bx = PW; m_dx = 1; end
         else if (nx <= 0) m_point(1'b1);
         else m_bx = nx;
      end else begin
         if (m_bx <= H - PW - B && nx >= H - PW - B && overlap(ny, B, pr0, PH)) begin
            m_bx = H - PW - B; m_dx = 0;
         end else if (nx >= H - B) m_point(1'b0);
         else m_bx = nx;
      end
   endtask

   always @(negedge i_clock) begin
      if (chk_on) begin
         chk("state",   int'(o_state),      m_st);
         chk("paddle_l", int'(o_paddle_l_y), m_pl);
         chk("paddle_r", int'(o_paddle_r_y), m_pr);
         chk("ball_x",  int'(o_ball_x),     m_bx);
         chk("ball_y",  int'(o_ball_y),     m_by);
         chk("score_l", int'(o_score_l),    m_sl);
         chk("score_r", int'(o_score_r),    m_sr);
         chk("winner",  int'(o_winner),     m_win);
      end
   end

   task automatic cyc(input bit rst, input bit tick, input bit start,
                      input logic [1:0] up, input logic [1:0] dn);
      i_reset = rst; i_frame_tick = tick; i_start = start;
      i_up_but = up; i_down_but = dn;
      @(posedge i_clock);
      m_step(rst, tick, start, up, dn);
      @(negedge i_clock);
   endtask

   // a tick followed by an idle cycle, so non-tick cycles are also checked
   task automatic tick(input logic [1:0] up, input logic [1:0] dn);
      cyc(1'b1, 1'b1, 1'b0, up, dn);
      cyc(1'b1, 1'b0, 1'b0, up, dn);
   endtask

   initial begin
      int guard;
      int prev_sl, rmiss;
      @(negedge i_clock);
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      chk_on = 1'b1;
      cyc(1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
      cyc(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
      chk("rst_state", int'(o_state), 0);
      chk("rst_pad_l", int'(o_paddle_l_y), 208);
      chk("rst_pad_r", int'(o_paddle_r_y), 208);
      chk("rst_ball_x", int'(o_ball_x), 316);
      chk("rst_ball_y", int'(o_ball_y), 236);
      chk("rst_scores", int'(o_score_l) + int'(o_score_r), 0);

      cyc(1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
      chk("start_state", int'(o_state), 1);
      repeat (61) tick(2'b00, 2'b00);
      chk("serve_to_play", int'(o_state), 2);
      tick(2'b00, 2'b00);
      chk("first_move_x", int'(o_ball_x), 318);
      chk("first_move_y", int'(o_ball_y), 238);

      repeat (3) tick(2'b01, 2'b01);
      chk("both_btn_hold", int'(o_paddle_l_y), 208);
      repeat (2) tick(2'b00, 2'b01);
      chk("down_step", int'(o_paddle_l_y), 216);
      repeat (60) tick(2'b11, 2'b00);
      chk("clamp_top_l", int'(o_paddle_l_y), 0);
      repeat (3) tick(2'b01, 2'b01);
      chk("clamp_both_btn", int'(o_paddle_l_y), 0);

`ifndef PONG_AI_PLAYER_EN
      chk("clamp_top_r", int'(o_paddle_r_y), 0);
      guard = 0;
      while (o_state != 2'd1 && guard < 400) begin tick(2'b11, 2'b00); guard++; end
      chk("miss_state", int'(o_state), 1);
      chk("miss_score_l", int'(o_score_l), 1);
      chk("miss_score_r", int'(o_score_r), 0);
      repeat (62) tick(2'b11, 2'b00);
      chk("reserve_right", int'(o_ball_x), 318);

      guard = 0;
      while (o_state != 2'd3 && guard < 4000) begin
         if (o_ball_y < 10'd236) tick(2'b01, 2'b10);
         else                     tick(2'b11, 2'b00);
         guard++;
      end
      chk("over_state", int'(o_state), 3);
      chk("over_winner", int'(o_winner), 0);
      chk("over_score_l", int'(o_score_l), 7);
      repeat (5) tick(2'b00, 2'b11);
      chk("frozen_pad_l", int'(o_paddle_l_y), 0);
      chk("frozen_ball_x", int'(o_ball_x), 316);
      chk("frozen_ball_y", int'(o_ball_y), 236);
      cyc(1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
      chk("restart_state", int'(o_state), 1);
      chk("restart_score", int'(o_score_l) + int'(o_score_r), 0);
`else
      prev_sl = int'(o_score_l);
      rmiss = 0;
      for (int i = 0; i < 2000; i++) begin
         if (o_state == 2'd0 || o_state == 2'd3) cyc(1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
         tick(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         if (int'(o_score_l) > prev_sl) rmiss++;
         prev_sl = int'(o_score_l);
      end
      chk("ai_no_right_miss", rmiss, 0);
`endif

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0)
            cyc(1'b0, 1'b1, 1'b1, 2'($urandom), 2'($urandom));
         else
            cyc(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
                2'($urandom), 2'($urandom));
      end

      guard = 0;
      while (o_state != 2'd2 && guard < 300) begin
         cyc(1'b1, 1'b1, 1'b1, 2'b00, 2'b00);
         guard++;
      end
      chk("reach_play", int'(o_state), 2);
      cyc(1'b0, 1'b1, 1'b1, 2'b11, 2'b00);
      chk("midplay_rst_state", int'(o_state), 0);
      chk("midplay_rst_ball_x", int'(o_ball_x), 316);
      chk("midplay_rst_pad_l", int'(o_paddle_l_y), 208);
      chk("midplay_rst_score", int'(o_score_l) + int'(o_score_r), 0);

      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
